bus_copy_initiator: RTL and testbench

//  Bus initiator (master) on the native valid/ready/wstrb/addr/wdata/rdata memory bus used by our

---
 rtl/bus_copy_initiator.sv | 128 ++++++++++++
 tb/tb_bus_copy_initiator.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_copy_initiator.sv
// Bus-master word copier: reads LEN words from SRC and writes them to DST over the
// native valid/ready memory bus, one read then one write per word, with a ready timeout.
module bus_copy_initiator #(
    parameter int unsigned LEN_W   = 16,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic [31:0]      i_src,
    input  logic [31:0]      i_dst,
    input  logic [LEN_W-1:0] i_len,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_error,
    output logic [LEN_W-1:0] o_words_done,
    output logic             o_mem_valid,
    input  logic             i_mem_ready,
    output logic [3:0]       o_mem_wstrb,
    output logic [31:0]      o_mem_addr,
    output logic [31:0]      o_mem_wdata,
    input  logic [31:0]      i_mem_rdata
);

    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {StIdle, StRd, StRgap, StWr, StWgap} state_t;

    state_t             r_state;
    state_t             w_state_d;
    logic [31:0]        r_src;
    logic [31:0]        r_dst;
    logic [31:0]        r_data;
    logic [LEN_W-1:0]   r_len;
    logic [LEN_W-1:0]   r_words;
    logic [CNT_W-1:0]   r_wait;
    logic               r_done;
    logic               r_error;

    logic               w_req;
    logic               w_hs;
    logic               w_tmo;
    logic               w_last;
    logic               w_unused_bits;

    assign w_unused_bits = ^{i_src[1:0], i_dst[1:0]};

    assign w_req  = (r_state == StRd) || (r_state == StWr);
    assign w_hs   = w_req && i_mem_ready;
    // A ready on the limit cycle is a handshake, so the timeout needs ready low.
    assign w_tmo  = w_req && !i_mem_ready && (TIMEOUT != 0) &&
                    (r_wait == CNT_W'(TIMEOUT - 1));
    assign w_last = (r_words + 1'b1) == r_len;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        case (r_state)
            StIdle: begin
                if (i_start && (i_len != '0)) w_state_d = StRd;
            end
            StRd: begin
                if (w_hs)       w_state_d = StRgap;
                else if (w_tmo) w_state_d = StIdle;
            end
            StRgap: w_state_d = StWr;
            StWr: begin
                if (w_hs)       w_state_d = w_last ? StIdle : StWgap;
                else if (w_tmo) w_state_d = StIdle;
            end
            StWgap: w_state_d = StRd;
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_src   <= '0;
            r_dst   <= '0;
            r_data  <= '0;
            r_len   <= '0;
            r_words <= '0;
            r_wait  <= '0;
            r_done  <= 1'b0;
            r_error <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if ((r_state == StIdle) && i_start) begin
                r_error <= 1'b0;
                r_words <= '0;
                r_src   <= {i_src[31:2], 2'b00};
                r_dst   <= {i_dst[31:2], 2'b00};
                r_len   <= i_len;
                r_done  <= (i_len == '0);
            end
            if (w_req && !w_hs) r_wait <= r_wait + 1'b1;
            else                r_wait <= '0;
            if ((r_state == StRd) && w_hs) r_data <= i_mem_rdata;
            if ((r_state == StWr) && w_hs) begin
                r_words <= r_words + 1'b1;
                r_src   <= r_src + 32'd4;
                r_dst   <= r_dst + 32'd4;
                if (w_last) r_done <= 1'b1;
            end
            if (w_tmo) begin
                r_error <= 1'b1;
                r_done  <= 1'b1;
            end
        end
    end

    assign o_busy       = (r_state != StIdle);
    assign o_done       = r_done;
    assign o_error      = r_error;
    assign o_words_done = r_words;
    assign o_mem_valid  = w_req;
    assign o_mem_wstrb  = (r_state == StWr) ? 4'hF : 4'h0;
    assign o_mem_addr   = (r_state == StWr) ? r_dst : r_src;
    assign o_mem_wdata  = r_data;

endmodule

// File: tb/tb_bus_copy_initiator.sv
// Directed bench for bus_copy_initiator: table of copy jobs against a variable-wait
// responder, plus hand-written timeout and mid-transfer reset sequences.
module tb_bus_copy_initiator;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] src;
    logic [31:0] dst;
    logic [15:0] len;
    logic        busy;
    logic        done;
    logic        error;
    logic [15:0] words_done;
    logic        mem_valid;
    logic        mem_ready;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    always #5 clk = ~clk;

    bus_copy_initiator #(
        .LEN_W   (16),
        .TIMEOUT (8)
    ) dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_start      (start),
        .i_src        (src),
        .i_dst        (dst),
        .i_len        (len),
        .o_busy       (busy),
        .o_done       (done),
        .o_error      (error),
        .o_words_done (words_done),
        .o_mem_valid  (mem_valid),
        .i_mem_ready  (mem_ready),
        .o_mem_wstrb  (mem_wstrb),
        .o_mem_addr   (mem_addr),
        .o_mem_wdata  (mem_wdata),
        .i_mem_rdata  (mem_rdata)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
        else n_pass++;
    endtask

    function automatic logic [31:0] pat(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A3C_0F96;
    endfunction

    // Responder: ready after a wait of wmin..wmax negedges, dropped after each handshake.
    logic        resp_en;
    int          wmin;
    int          wmax;
    int          wleft;
    logic        in_req;
    logic [31:0] cur_addr;
    logic [31:0] cur_wdata;
    logic [3:0]  cur_wstrb;
    logic [31:0] rd_q[$];
    logic [31:0] wr_aq[$];
    logic [31:0] wr_dq[$];

    always @(negedge clk) begin
        if (rst || !resp_en) begin
            mem_ready = 1'b0;
            in_req    = 1'b0;
        end else if (mem_ready) begin
            mem_ready = 1'b0;
            in_req    = 1'b0;
            check("gap_after_handshake", {31'd0, mem_valid}, 32'd0);
        end else if (mem_valid) begin
            if (!in_req) begin
                in_req    = 1'b1;
                cur_addr  = mem_addr;
                cur_wdata = mem_wdata;
                cur_wstrb = mem_wstrb;
                wleft     = wmin + int'($urandom_range(wmax - wmin, 0));
                check("wstrb_legal", {31'd0, (mem_wstrb == 4'h0) || (mem_wstrb == 4'hF)}, 32'd1);
            end else begin
                check("addr_stable", mem_addr, cur_addr);
                check("wdata_stable", mem_wdata, cur_wdata);
                check("wstrb_stable", {28'd0, mem_wstrb}, {28'd0, cur_wstrb});
            end
            if (wleft == 0) begin
                mem_ready = 1'b1;
                if (mem_wstrb == 4'h0) begin
                    mem_rdata = pat(mem_addr);
                    rd_q.push_back(mem_addr);
                end else begin
                    wr_aq.push_back(mem_addr);
                    wr_dq.push_back(mem_wdata);
                end
            end else begin
                wleft--;
            end
        end
    end

    typedef struct {
        logic [31:0] src;
        logic [31:0] dst;
        logic [15:0] len;
        int          wmin;
        int          wmax;
        bit          mid;
        int          exp_cyc;
    } vec_t;

    vec_t vecs[6];

    task automatic run_copy(input vec_t v);
        int          dc;
        logic [31:0] base_s;
        logic [31:0] base_d;
        dc     = -1;
        base_s = {v.src[31:2], 2'b00};
        base_d = {v.dst[31:2], 2'b00};
        rd_q.delete();
        wr_aq.delete();
        wr_dq.delete();
        wmin    = v.wmin;
        wmax    = v.wmax;
        resp_en = 1'b1;
        @(negedge clk);
        start = 1'b1;
        src   = v.src;
        dst   = v.dst;
        len   = v.len;
        for (int c = 1; c <= 400 && dc < 0; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (v.mid && c == 3) begin
                start = 1'b1;
                src   = 32'hDEAD_0000;
                len   = 16'd7;
            end
            if (c == 1) begin
                check("busy_first_cycle", {31'd0, busy}, {31'd0, v.len != 0});
                check("error_cleared", {31'd0, error}, 32'd0);
            end
            if (done) dc = c;
        end
        start = 1'b0;
        check("done_seen", {31'd0, dc > 0}, 32'd1);
        if (v.exp_cyc > 0) check("done_cycle", dc, v.exp_cyc);
        check("busy_at_done", {31'd0, busy}, 32'd0);
        check("words_done", {16'd0, words_done}, {16'd0, v.len});
        check("error_at_done", {31'd0, error}, 32'd0);
        check("read_count", rd_q.size(), {16'd0, v.len});
        check("write_count", wr_aq.size(), {16'd0, v.len});
        for (int i = 0; i < int'(v.len) && i < rd_q.size() && i < wr_aq.size(); i++) begin
            check("read_addr", rd_q[i], base_s + 32'(4 * i));
            check("write_addr", wr_aq[i], base_d + 32'(4 * i));
            check("write_data", wr_dq[i], pat(base_s + 32'(4 * i)));
        end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("done_pulse_one", {31'd0, done}, 32'd0);
            check("idle_no_valid", {31'd0, mem_valid}, 32'd0);
            check("idle_not_busy", {31'd0, busy}, 32'd0);
        end
    endtask

    initial begin
        int   dc;
        int   vcnt;
        logic found;
        vecs[0] = '{32'h0000_0100, 32'h0000_0200, 16'd3, 1, 1, 1'b0, 18};
        vecs[1] = '{32'h0000_0010, 32'h0000_0020, 16'd0, 1, 1, 1'b0, 1};
        vecs[2] = '{32'hFFFF_FFFC, 32'h0000_0800, 16'd2, 1, 1, 1'b1, 12};
        vecs[3] = '{32'h0000_0303, 32'h0000_1002, 16'd4, 1, 6, 1'b0, 0};
        vecs[4] = '{32'h0000_2000, 32'h0000_3000, 16'd1, 7, 7, 1'b0, 18};
        vecs[5] = '{32'h0000_4000, 32'hFFFF_FFF8, 16'd3, 1, 6, 1'b0, 0};

        rst       = 1'b1;
        start     = 1'b0;
        src       = '0;
        dst       = '0;
        len       = '0;
        resp_en   = 1'b0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        wmin      = 1;
        wmax      = 1;
        #1;
        check("rst_valid", {31'd0, mem_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_error", {31'd0, error}, 32'd0);
        check("rst_words", {16'd0, words_done}, 32'd0);
        check("rst_addr", mem_addr, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) run_copy(vecs[i]);

        // Responder silent: valid for 8 cycles, then abort with error.
        resp_en = 1'b0;
        @(negedge clk);
        start = 1'b1;
        src   = 32'h400;
        dst   = 32'h500;
        len   = 16'd2;
        dc    = -1;
        vcnt  = 0;
        for (int c = 1; c <= 40 && dc < 0; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (mem_valid) vcnt++;
            if (done) dc = c;
        end
        check("tmo_valid_cycles", vcnt, 8);
        check("tmo_done_cycle", dc, 9);
        check("tmo_error", {31'd0, error}, 32'd1);
        check("tmo_words", {16'd0, words_done}, 32'd0);
        check("tmo_busy", {31'd0, busy}, 32'd0);
        repeat (3) @(negedge clk);
        check("tmo_error_sticky", {31'd0, error}, 32'd1);
        check("tmo_no_valid", {31'd0, mem_valid}, 32'd0);

        run_copy('{32'h0000_5000, 32'h0000_6000, 16'd2, 1, 3, 1'b0, 0});

        // Reset asserted while a write is pending.
        wmin    = 3;
        wmax    = 3;
        resp_en = 1'b1;
        @(negedge clk);
        start = 1'b1;
        src   = 32'h700;
        dst   = 32'h900;
        len   = 16'd3;
        found = 1'b0;
        for (int c = 1; c <= 60 && !found; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (mem_valid && mem_wstrb == 4'hF) found = 1'b1;
        end
        check("reached_write", {31'd0, found}, 32'd1);
        rst = 1'b1;
        #1;
        check("rst_wr_valid", {31'd0, mem_valid}, 32'd0);
        check("rst_wr_busy", {31'd0, busy}, 32'd0);
        check("rst_wr_done", {31'd0, done}, 32'd0);
        check("rst_wr_words", {16'd0, words_done}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        run_copy('{32'h0000_0A00, 32'h0000_0B00, 16'd2, 1, 1, 1'b0, 12});

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
